// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives sync-read imem, buffers into a 2-entry queue.
// Optional FETCH_JMP_FOLD_EN: fold JMP responses in fetch instead of delivering them.
module fetch_unit #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned IW       = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IW-1:0]   imem_data,
  output logic            ir_valid,
  input  logic            ir_ready,
  output logic [IW-1:0]   ir_data,
  output logic [PC_W-1:0] ir_pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            halted
);

  localparam logic [4:0] OP_HLT = 5'b01100;
`ifdef FETCH_JMP_FOLD_EN
  localparam logic [4:0] OP_JMP = 5'b01111;
`endif

  typedef enum logic {RUN, HALT} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic            inflight, inflight_discard;
  logic [PC_W-1:0] inflight_pc;
  logic            v1;
  logic [IW-1:0]   d1;
  logic [PC_W-1:0] p1;

  logic            pop, issue, push, fold, redir, resp_ok, discard_nxt;
  logic [1:0]      occ;
  logic            nv0, nv1;
  logic [IW-1:0]   nd0, nd1;
  logic [PC_W-1:0] np0, np1;

  assign resp_ok   = inflight & ~inflight_discard;
  assign imem_en   = issue;
  assign imem_addr = pc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next-state, issue decision and queue update
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pop         = 1'b0;
    issue       = 1'b0;
    push        = 1'b0;
    fold        = 1'b0;
    redir       = 1'b0;
    discard_nxt = 1'b0;
    occ         = 2'd0;
    nv0         = ir_valid;
    nv1         = v1;
    nd0         = ir_data;
    np0         = ir_pc;
    nd1         = d1;
    np1         = p1;
    if (state == RUN) begin
      redir = redirect_valid;
      pop   = ir_valid & ir_ready;
      // Occupancy counts a discarded in-flight slot too; keeps the queue bound simple.
      occ   = 2'(ir_valid) + 2'(v1) + 2'(inflight) - 2'(pop);
      issue = ~rst & ~redir & (occ < 2'd2);
`ifdef FETCH_JMP_FOLD_EN
      fold  = resp_ok & ~redir & (imem_data[IW-1 -: 5] == OP_JMP);
`endif
      push  = resp_ok & ~redir & ~fold;
      if (pop) begin
        nv0 = v1;
        nd0 = d1;
        np0 = p1;
        nv1 = 1'b0;
      end
      if (push) begin
        if (!nv0) begin
          nv0 = 1'b1;
          nd0 = imem_data;
          np0 = inflight_pc;
        end else begin
          nv1 = 1'b1;
          nd1 = imem_data;
          np1 = inflight_pc;
        end
      end
      if (issue) pc_nxt = pc + PC_W'(1);
`ifdef FETCH_JMP_FOLD_EN
      if (fold) begin
        pc_nxt      = PC_W'(imem_data[7:0]);
        discard_nxt = issue;
      end
`endif
      if (redir) begin
        nv0    = 1'b0;
        nv1    = 1'b0;
        pc_nxt = redirect_pc;
      end else if (pop && (ir_data[IW-1 -: 5] == OP_HLT)) begin
        state_nxt = HALT;
        nv0       = 1'b0;
        nv1       = 1'b0;
      end
    end else begin
      nv0 = 1'b0;
      nv1 = 1'b0;
    end
  end

  // Datapath registers: PC, in-flight tracking, queue, halted flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pc               <= PC_W'(RESET_PC);
      inflight         <= 1'b0;
      inflight_discard <= 1'b0;
      inflight_pc      <= '0;
      ir_valid         <= 1'b0;
      ir_data          <= '0;
      ir_pc            <= '0;
      v1               <= 1'b0;
      d1               <= '0;
      p1               <= '0;
      halted           <= 1'b0;
    end else begin
      pc               <= pc_nxt;
      inflight         <= issue;
      inflight_discard <= discard_nxt;
      inflight_pc      <= pc;
      ir_valid         <= nv0;
      ir_data          <= nd0;
      ir_pc            <= np0;
      v1               <= nv1;
      d1               <= nd1;
      p1               <= np1;
      halted           <= (state_nxt == HALT);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, stall, redirect, halt, mid-run reset, JMP handling.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data = 16'h0;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_data;
  logic [7:0]  ir_pc;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halted;

  logic [15:0] mem [256];
  int          n_pass = 0;
  int          n_total = 0;

  fetch_unit #(.PC_W(8), .IW(16), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory
  always @(posedge clk) if (imem_en) imem_data <= mem[imem_addr];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int got;
    logic [7:0] pcs [4];
    logic [7:0] exp_pcs [4];

    for (int i = 0; i < 256; i++) mem[i] = 16'h4000 | 16'(i);
    rst = 1'b1;
    ir_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;

    // T1: reset values, first fetch latency, streaming
    tick(); tick(); #1;
    chk("rst_imem_en",   32'(imem_en),   0);
    chk("rst_imem_addr", 32'(imem_addr), 0);
    chk("rst_ir_valid",  32'(ir_valid),  0);
    chk("rst_ir_data",   32'(ir_data),   0);
    chk("rst_ir_pc",     32'(ir_pc),     0);
    chk("rst_halted",    32'(halted),    0);
    rst = 1'b0; #1;
    chk("t1_c0_en",   32'(imem_en),   1);
    chk("t1_c0_addr", 32'(imem_addr), 0);
    tick();
    chk("t1_c1_valid", 32'(ir_valid),  0);
    chk("t1_c1_addr",  32'(imem_addr), 1);
    tick();
    chk("t1_c2_valid", 32'(ir_valid), 1);
    chk("t1_c2_data",  32'(ir_data),  32'h4000);
    for (int k = 0; k < 4; k++) begin
      chk("t1_stream_pc",    32'(ir_pc),    k);
      chk("t1_stream_valid", 32'(ir_valid), 1);
      tick();
    end

    // T2: backpressure holds the head; queue caps at two
    ir_ready = 1'b0;
    do_reset();
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold_valid", 32'(ir_valid), 1);
      chk("t2_hold_pc",    32'(ir_pc),    0);
      chk("t2_hold_data",  32'(ir_data),  32'h4000);
      if (k > 0) chk("t2_hold_noissue", 32'(imem_en), 0);
      tick();
    end
    ir_ready = 1'b1; #1;
    chk("t2_rel_en",   32'(imem_en),   1);
    chk("t2_rel_addr", 32'(imem_addr), 2);
    for (int k = 0; k < 4; k++) begin
      chk("t2_rel_pc",    32'(ir_pc),    k);
      chk("t2_rel_valid", 32'(ir_valid), 1);
      tick();
    end

    // T3: redirect to 0xFE at cycle 6, PC wraps
    do_reset();
    repeat (6) tick();
    redirect_valid = 1'b1;
    redirect_pc = 8'hFE;
    #1;
    chk("t3_c6_en",    32'(imem_en),  0);
    chk("t3_c6_pc",    32'(ir_pc),    4);
    chk("t3_c6_valid", 32'(ir_valid), 1);
    tick();
    redirect_valid = 1'b0; #1;
    chk("t3_c7_valid", 32'(ir_valid),  0);
    chk("t3_c7_en",    32'(imem_en),   1);
    chk("t3_c7_addr",  32'(imem_addr), 32'hFE);
    tick();
    chk("t3_c8_valid", 32'(ir_valid),  0);
    chk("t3_c8_addr",  32'(imem_addr), 32'hFF);
    tick();
    exp_pcs[0] = 8'hFE; exp_pcs[1] = 8'hFF; exp_pcs[2] = 8'h00; exp_pcs[3] = 8'h01;
    for (int k = 0; k < 4; k++) begin
      chk("t3_new_pc",    32'(ir_pc),    32'(exp_pcs[k]));
      chk("t3_new_valid", 32'(ir_valid), 1);
      tick();
    end

    // T4: HLT at address 3, then permanently stopped
    mem[3] = 16'h6000;
    do_reset();
    repeat (5) tick();
    chk("t4_hlt_pc",     32'(ir_pc),    3);
    chk("t4_hlt_data",   32'(ir_data),  32'h6000);
    chk("t4_hlt_valid",  32'(ir_valid), 1);
    chk("t4_pre_halted", 32'(halted),   0);
    tick();
    chk("t4_halted", 32'(halted), 1);
    for (int k = 0; k < 20; k++) begin
      redirect_valid = (k == 3);
      redirect_pc = 8'h40;
      #1;
      chk("t4_halt_en",    32'(imem_en),  0);
      chk("t4_halt_valid", 32'(ir_valid), 0);
      tick();
    end
    redirect_valid = 1'b0;
    chk("t4_still_halted", 32'(halted), 1);
    mem[3] = 16'h4003;

    // T5: reset mid-run with a full, stalled queue
    ir_ready = 1'b0;
    do_reset();
    repeat (3) tick();
    chk("t5_full_valid", 32'(ir_valid), 1);
    rst = 1'b1; #1;
    chk("t5_rst_en", 32'(imem_en), 0);
    tick();
    chk("t5_rst_valid", 32'(ir_valid),  0);
    chk("t5_rst_pc",    32'(ir_pc),     0);
    chk("t5_rst_data",  32'(ir_data),   0);
    chk("t5_rst_addr",  32'(imem_addr), 0);
    rst = 1'b0;
    ir_ready = 1'b1;
    #1;
    chk("t5_c0_en",   32'(imem_en),   1);
    chk("t5_c0_addr", 32'(imem_addr), 0);
    tick();
    chk("t5_c1_valid", 32'(ir_valid), 0);
    tick();
    chk("t5_c2_pc",   32'(ir_pc),   0);
    chk("t5_c2_data", 32'(ir_data), 32'h4000);
    tick();
    chk("t5_c3_pc", 32'(ir_pc), 1);

    // T6: JMP 0x10 at address 2
    mem[2] = 16'h7810;
`ifdef FETCH_JMP_FOLD_EN
    exp_pcs[0] = 8'h00; exp_pcs[1] = 8'h01; exp_pcs[2] = 8'h10; exp_pcs[3] = 8'h11;
`else
    exp_pcs[0] = 8'h00; exp_pcs[1] = 8'h01; exp_pcs[2] = 8'h02; exp_pcs[3] = 8'h03;
`endif
    do_reset();
    got = 0;
    for (int c = 0; c < 25; c++) begin
      if (ir_valid && got < 4) begin
        pcs[got] = ir_pc;
        got++;
      end
      tick();
    end
    chk("t6_count", 32'(got), 4);
    for (int k = 0; k < 4; k++)
      if (k < got) chk("t6_pc", 32'(pcs[k]), 32'(exp_pcs[k]));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
